// File: rtl/uart_frame_pkg.sv
// Shared constants and enums for the UART command-frame parser.
package uart_frame_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hAA;
  localparam logic [7:0] FTR_BYTE  = 8'h55;
  localparam logic [7:0] ACK_BYTE  = 8'hEE;
  localparam logic [7:0] NACK_BYTE = 8'hFF;

  localparam logic [3:0] TYPE_ACU   = 4'h1;
  localparam logic [3:0] TYPE_PLANK = 4'h2;
  localparam logic [3:0] TYPE_SNSR  = 4'h4;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_CHK  = 3'd1,
    ERR_FTR  = 3'd2,
    ERR_TYPE = 3'd3,
    ERR_TMO  = 3'd4
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_CHK,
    ST_FTR
  } state_e;

endpackage

// File: rtl/uart_rsp_reg.sv
// Single-entry ACK/NACK holding register with ready handshake.
// A newly raised response overwrites one that is still pending.
module uart_rsp_reg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       set_i,
  input  logic [7:0] byte_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] byte_o
);

  logic       valid_q, valid_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    valid_d = valid_q;
    byte_d  = byte_q;
    if (set_i) begin
      valid_d = 1'b1;
      byte_d  = byte_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      byte_q  <= byte_d;
    end
  end

  assign valid_o = valid_q;
  assign byte_o  = byte_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Parses AA,cmd,payload[N],chk,55 frames and raises ACK/NACK responses.
// Define UART_FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYC idle clocks.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int ACU_LEN     = 5,
  parameter int PLANK_LEN   = 18,
  parameter int SNSR_LEN    = 1,
  parameter int TIMEOUT_CYC = 17360
) (
  input  logic                 i_clk_100,
  input  logic                 i_rst_n,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_byte,
  output logic                 o_frm_valid,
  output logic [7:0]           o_frm_cmd,
  output logic [5:0]           o_frm_len,
  output logic [MAX_LEN*8-1:0] o_payload,
  output logic                 o_rsp_valid,
  output logic [7:0]           o_rsp_byte,
  input  logic                 i_rsp_ready,
  output logic [2:0]           o_err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (ACU_LEN > MAX_LEN || PLANK_LEN > MAX_LEN || SNSR_LEN > MAX_LEN || MAX_LEN > 63) begin : g_len_chk
    $fatal(1, "uart_frame_parser: a frame length exceeds MAX_LEN (or MAX_LEN > 63)");
  end

  state_e                    state_q, state_d;
  err_e                      err_q, err_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                xor_q, xor_d;
  logic [7:0]                cmd_q, cmd_d;
  logic [5:0]                len_q, len_d;
  logic                      match_q, match_d;
  logic [MAX_LEN-1:0][7:0]   buf_q, buf_d;
  logic                      frm_valid_q, frm_valid_d;
  logic [7:0]                frm_cmd_q, frm_cmd_d;
  logic [5:0]                frm_len_q, frm_len_d;
  logic [MAX_LEN-1:0][7:0]   payload_q, payload_d;
  logic                      type_ok;
  logic [5:0]                type_len;
  logic                      rsp_set;
  logic [7:0]                rsp_byte;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]          tmo_q, tmo_d;
`endif

  always_comb begin
    type_ok  = 1'b1;
    type_len = 6'd0;
    case (i_rx_byte[3:0])
      TYPE_ACU:   type_len = 6'(ACU_LEN);
      TYPE_PLANK: type_len = 6'(PLANK_LEN);
      TYPE_SNSR:  type_len = 6'(SNSR_LEN);
      default:    type_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    match_d     = match_q;
    buf_d       = buf_q;
    frm_valid_d = 1'b0;
    frm_cmd_d   = frm_cmd_q;
    frm_len_d   = frm_len_q;
    payload_d   = payload_q;
    rsp_set     = 1'b0;
    rsp_byte    = ACK_BYTE;
    if (i_rx_valid) begin
      case (state_q)
        ST_IDLE: if (i_rx_byte == HDR_BYTE) begin
          state_d = ST_CMD;
          xor_d   = HDR_BYTE;
          err_d   = ERR_NONE;
        end
        ST_CMD: begin
          xor_d = xor_q ^ i_rx_byte;
          cmd_d = i_rx_byte;
          len_d = type_len;
          idx_d = '0;
          if (type_ok) state_d = ST_PAYLOAD;
          else begin
            state_d = ST_IDLE;
            err_d   = ERR_TYPE;
          end
        end
        ST_PAYLOAD: begin
          // A header byte here is plain data; there is no resync.
          buf_d[idx_q] = i_rx_byte;
          xor_d        = xor_q ^ i_rx_byte;
          if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
            state_d = ST_CHK;
            idx_d   = '0;
          end else if (32'(idx_q) != 32'(MAX_LEN - 1)) begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_CHK: begin
          match_d = (i_rx_byte == xor_q);
          state_d = ST_FTR;
        end
        ST_FTR: begin
          state_d = ST_IDLE;
          rsp_set = 1'b1;
          if (!match_q) begin
            err_d    = ERR_CHK;
            rsp_byte = NACK_BYTE;
          end else if (i_rx_byte != FTR_BYTE) begin
            err_d    = ERR_FTR;
            rsp_byte = NACK_BYTE;
          end else begin
            frm_valid_d = 1'b1;
            frm_cmd_d   = cmd_q;
            frm_len_d   = len_q;
            payload_d   = buf_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef UART_FRAME_TIMEOUT_EN
    tmo_d = (state_q == ST_IDLE || i_rx_valid) ? '0 : tmo_q + 1'b1;
    if (state_q != ST_IDLE && !i_rx_valid && 32'(tmo_q) == 32'(TIMEOUT_CYC - 1)) begin
      state_d  = ST_IDLE;
      err_d    = ERR_TMO;
      rsp_set  = 1'b1;
      rsp_byte = NACK_BYTE;
      tmo_d    = '0;
    end
`endif
  end

  always_ff @(posedge i_clk_100) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      err_q       <= ERR_NONE;
      idx_q       <= '0;
      xor_q       <= 8'h00;
      cmd_q       <= 8'h00;
      len_q       <= 6'd0;
      match_q     <= 1'b0;
      frm_valid_q <= 1'b0;
      frm_cmd_q   <= 8'h00;
      frm_len_q   <= 6'd0;
      payload_q   <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      match_q     <= match_d;
      frm_valid_q <= frm_valid_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_len_q   <= frm_len_d;
      payload_q   <= payload_d;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Working buffer needs no reset; only the good-frame copy is visible.
  always_ff @(posedge i_clk_100) buf_q <= buf_d;

  uart_rsp_reg u_rsp (
    .clk_i   (i_clk_100),
    .rst_ni  (i_rst_n),
    .set_i   (rsp_set),
    .byte_i  (rsp_byte),
    .ready_i (i_rsp_ready),
    .valid_o (o_rsp_valid),
    .byte_o  (o_rsp_byte)
  );

  assign o_frm_valid = frm_valid_q;
  assign o_frm_cmd   = frm_cmd_q;
  assign o_frm_len   = frm_len_q;
  assign o_payload   = payload_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized frame stream against a frame-level expectation model for uart_frame_parser.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 32, ACU_LEN = 5, PLANK_LEN = 18, SNSR_LEN = 1, TMO = 40;

  logic                 clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, rsp_ready = 1'b1;
  logic [7:0]           rx_byte = 8'h00;
  logic                 frm_valid, rsp_valid;
  logic [7:0]           frm_cmd, rsp_byte;
  logic [5:0]           frm_len;
  logic [MAX_LEN*8-1:0] payload;
  logic [2:0]           err;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN), .ACU_LEN(ACU_LEN), .PLANK_LEN(PLANK_LEN),
    .SNSR_LEN(SNSR_LEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk_100(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_frm_valid(frm_valid), .o_frm_cmd(frm_cmd), .o_frm_len(frm_len), .o_payload(payload),
    .o_rsp_valid(rsp_valid), .o_rsp_byte(rsp_byte), .i_rsp_ready(rsp_ready), .o_err(err)
  );

  int checks = 0, fails = 0;
  int frm_cnt = 0, rsp_cnt = 0, exp_frm_cnt = 0, exp_rsp_cnt = 0;
  logic [7:0] rsp_last = 8'h00, exp_rsp_last = 8'h00, exp_cmd = 8'h00;
  logic [5:0] exp_len = 6'd0;
  logic [MAX_LEN*8-1:0] exp_pl = '0, exp_mask = '1;
  logic [7:0] pl[$];

  // Observed good-frame pulses and accepted responses.
  always @(negedge clk) if (rst_n) begin
    if (frm_valid) frm_cnt++;
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      rsp_last = rsp_byte;
    end
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int tlen(input logic [3:0] t);
    case (t)
      4'h1:    return ACU_LEN;
      4'h2:    return PLANK_LEN;
      4'h4:    return SNSR_LEN;
      default: return 0;
    endcase
  endfunction

  function automatic int gap_n();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic settle(input logic [2:0] e);
    idle(1);
    check("frm_pulse_once", frm_valid, 1'b0);
    check("frm_count", frm_cnt, exp_frm_cnt);
    check("rsp_count", rsp_cnt, exp_rsp_cnt);
    check("rsp_last", rsp_last, exp_rsp_last);
    if (rsp_ready) check("rsp_cleared", rsp_valid, 1'b0);
    else           check("rsp_held", rsp_valid, 1'b1);
    check("err", err, e);
    check("frm_cmd", frm_cmd, exp_cmd);
    check("frm_len", frm_len, exp_len);
    check("payload", payload & exp_mask, exp_pl);
  endtask

  // Sends one frame built from pl; stall_at >= 0 idles after that payload byte.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] chk_x,
                            input logic [7:0] ftr, input int ngarb, input int stall_at);
    logic [7:0] x;
    int n;
    bit good;
    logic [2:0] e;
    for (int i = 0; i < ngarb; i++) begin
      x = 8'($urandom_range(0, 255));
      if (x == 8'hAA) x = 8'h00;
      put(x, gap_n());
    end
    n = tlen(cmd[3:0]);
    put(8'hAA, gap_n());
    if (n == 0) begin
      put(cmd, 0);
      if (rsp_ready) check("type_no_rsp", rsp_valid, 1'b0);
      settle(3'd3);
      return;
    end
    put(cmd, gap_n());
    x = 8'hAA ^ cmd;
    for (int i = 0; i < n; i++) begin
      x ^= pl[i];
      put(pl[i], gap_n());
      if (i == stall_at) begin
        idle(TMO + 20);
`ifdef UART_FRAME_TIMEOUT_EN
        if (rsp_ready) begin
          exp_rsp_cnt++;
          exp_rsp_last = 8'hFF;
        end
        settle(3'd4);
        return;
`else
        check("no_tmo_rsp", rsp_cnt, exp_rsp_cnt);
        check("no_tmo_err", err, 3'd0);
`endif
      end
    end
    put(x ^ chk_x, gap_n());
    put(ftr, 0);
    good = (chk_x == 8'h00) && (ftr == 8'h55);
    e = (chk_x != 8'h00) ? 3'd1 : (ftr != 8'h55) ? 3'd2 : 3'd0;
    check("frm_valid_t1", frm_valid, good);
    check("rsp_valid_t1", rsp_valid, 1'b1);
    check("rsp_byte_t1", rsp_byte, good ? 8'hEE : 8'hFF);
    if (good) begin
      exp_frm_cnt++;
      exp_cmd  = cmd;
      exp_len  = 6'(n);
      exp_pl   = '0;
      exp_mask = '0;
      for (int i = 0; i < n; i++) begin
        exp_pl[i*8 +: 8]   = pl[i];
        exp_mask[i*8 +: 8] = 8'hFF;
      end
    end
    if (rsp_ready) begin
      exp_rsp_cnt++;
      exp_rsp_last = good ? 8'hEE : 8'hFF;
    end
    settle(e);
  endtask

  task automatic fill(input int n, input logic [7:0] v, input bit rnd);
    pl.delete();
    for (int i = 0; i < n; i++)
      pl.push_back(!rnd ? v : ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [3:0] nib;
    logic [7:0] cx, ft;
    int kind, sel;
    idle(3);
    check("rst_outs", {frm_valid, frm_cmd, frm_len, rsp_valid, rsp_byte, err}, '0);
    check("rst_payload", payload, '0);
    rst_n = 1'b1;
    idle(1);

    fill(1, 8'h11, 0);  send_frame(8'h04, 8'h00, 8'h55, 0, -1);
    fill(18, 8'h32, 0); send_frame(8'hE2, 8'h00, 8'h55, 0, -1);
    fill(5, 8'h00, 1);  send_frame(8'h01, 8'h01, 8'h55, 0, -1);
    put(8'h00, 0); put(8'h13, 0);
    fill(1, 8'h11, 0);  send_frame(8'h04, 8'h00, 8'h55, 0, -1);
    send_frame(8'h07, 8'h00, 8'h55, 0, -1);
    fill(1, 8'h11, 0);  send_frame(8'h04, 8'h00, 8'h55, 0, -1);

    // Mid-frame stall: aborted with timeout, otherwise resumed.
    fill(18, 8'h00, 1); send_frame(8'h02, 8'h00, 8'h55, 0, 2);
    fill(1, 8'h11, 0);  send_frame(8'h04, 8'h00, 8'h55, 1, -1);

    // Two responses while the transmitter is not ready: only the newer survives.
    rsp_ready = 1'b0;
    fill(5, 8'h00, 1);  send_frame(8'h01, 8'h00, 8'h55, 0, -1);
    fill(1, 8'h00, 1);  send_frame(8'h14, 8'h00, 8'h5A, 0, -1);
    check("rsp_overwrite", rsp_byte, 8'hFF);
    rsp_ready = 1'b1;
    idle(1);
    exp_rsp_cnt++;
    exp_rsp_last = 8'hFF;
    check("rsp_one_seen", rsp_cnt, exp_rsp_cnt);
    check("rsp_seen_byte", rsp_last, 8'hFF);
    check("rsp_drop", rsp_valid, 1'b0);

    // Reset mid-frame with strobes during reset.
    put(8'hAA, 0); put(8'h02, 0); put(8'h33, 0);
    rst_n = 1'b0; rx_valid = 1'b1; rx_byte = 8'hAA;
    idle(2);
    rx_valid = 1'b0; rst_n = 1'b1;
    check("midrst_outs", {frm_valid, frm_cmd, frm_len, rsp_valid, rsp_byte, err}, '0);
    check("midrst_payload", payload, '0);
    exp_cmd = 8'h00; exp_len = 6'd0; exp_pl = '0; exp_mask = '1;
    put(8'h04, 0); put(8'h11, 0); put(8'hBF, 0); put(8'h55, 0);
    settle(3'd0);

    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 5));
      sel  = int'($urandom_range(0, 2));
      nib  = (sel == 0) ? 4'h1 : (sel == 1) ? 4'h2 : 4'h4;
      if (kind == 4) begin
        do nib = 4'($urandom_range(0, 15)); while (tlen(nib) != 0);
      end
      cx = (kind == 2 || kind == 5) ? 8'($urandom_range(1, 255)) : 8'h00;
      ft = 8'h55;
      if (kind == 3 || kind == 5) begin
        do ft = 8'($urandom_range(0, 255)); while (ft == 8'h55);
      end
      fill(tlen(nib), 8'h00, 1);
      send_frame({4'($urandom_range(0, 15)), nib}, cx, ft, int'($urandom_range(0, 2)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, meaning payload buffer depth in bytes.
REQ-002 SHALL have parameter ACU_LEN, default 5, meaning payload bytes for type 0x1.
REQ-003 SHALL have parameter PLANK_LEN, default 18, meaning payload bytes for type 0x2.
REQ-004 SHALL have parameter SNSR_LEN, default 1, meaning payload bytes for type 0x4.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 17360, meaning the inter-byte gap limit in clocks (2 characters at 115200 baud, 100 MHz).
REQ-006 SHALL have port i_clk_100, input, 1, the single clock; synchronous active-low reset.
REQ-007 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port i_rx_valid, input, 1, one-cycle strobe for a received byte.
REQ-009 SHALL have port i_rx_byte, input, 8, the received byte.
REQ-010 SHALL have ports o_frm_valid (output, 1, one-cycle good-frame strobe), o_frm_cmd (output, 8, command byte), o_frm_len (output, 6, payload count) and o_payload (output, MAX_LEN*8, payload, byte 0 in bits [7:0]).
REQ-011 SHALL have ports o_rsp_valid (output, 1), o_rsp_byte (output, 8) and i_rsp_ready (input, 1): the ACK/NACK byte to the transmitter.
REQ-012 SHALL have port o_err (output, 3, sticky-until-next-frame error code: 0 none, 1 checksum, 2 footer, 3 type, 4 timeout).

Function
REQ-013 SHALL parse frames of the form 0xAA, cmd, payload[N], chk, 0x55, where N is selected by cmd[3:0] (0x1 gives ACU_LEN, 0x2 gives PLANK_LEN, 0x4 gives SNSR_LEN).
REQ-014 SHALL compute chk as the XOR of the header, cmd and every payload byte.
REQ-015 SHALL use FSM states IDLE, CMD, PAYLOAD, CHK, FTR.
- IDLE: discards any byte other than 0xAA; 0xAA moves to CMD.
- CMD: a valid type moves to PAYLOAD; an invalid type sets err=3 and returns to IDLE.
- PAYLOAD: stores bytes at an index that counts 0..N-1, then moves to CHK.
- CHK: records the match result and moves to FTR.
- FTR: a footer of 0x55 with a checksum match produces a good frame. Otherwise err is set (checksum error takes precedence over footer error). The FSM returns to IDLE in all cases.
REQ-016 SHALL assert o_frm_valid exactly 1 cycle after the strobe of the footer byte, with cmd, len and payload stable until the next good frame.
REQ-017 SHALL raise a response 1 cycle after the footer: 0xEE on good, 0xFF on checksum or footer error; type errors produce no response.
REQ-018 SHALL hold o_rsp_valid and o_rsp_byte until the cycle with i_rsp_ready=1, then deassert on the next cycle.
REQ-019 SHALL overwrite the pending response with the newer one if a new response is raised while one is pending; o_rsp_valid stays high.
REQ-020 SHALL capture a 0xAA received in PAYLOAD as data, with no resynchronisation.
REQ-021 SHALL ignore i_rx_valid while i_rst_n=0.
REQ-022 SHALL clear o_err to 0 on the next 0xAA accepted in IDLE.
REQ-023 SHALL hold the payload-index counter saturating at MAX_LEN-1; a parameter with any length exceeding MAX_LEN is a fatal elaboration error.

Reset
REQ-024 SHALL, while i_rst_n=0 at a clock edge, put the FSM in IDLE and clear the index, the running XOR and the timeout counter.
REQ-025 SHALL reset o_frm_valid=0, o_frm_cmd=0, o_frm_len=0, o_payload=0, o_rsp_valid=0, o_rsp_byte=0 and o_err=0.
REQ-026 SHALL discard any partial frame on reset asserted mid-frame, with no response.

Configuration
REQ-027 SHALL, with macro UART_FRAME_TIMEOUT_EN defined, count clocks outside IDLE since the last strobe.
- Reaching TIMEOUT_CYC returns the FSM to IDLE with err=4 and sends response 0xFF.
- Without the macro, the counter and err=4 are absent and the FSM waits indefinitely.

Structure
REQ-028 SHALL place in package uart_frame_pkg: the header, footer, ACK and NACK constants, the type-code constants, the error-code enum and the FSM state enum.
REQ-029 SHALL instantiate one sub-module, uart_rsp_reg, holding the response register and ready handshake.

Verification
REQ-030 SHALL cover: SNSR frame AA 04 11 BF 55 -> o_frm_valid 1 cycle after the 0x55, cmd=0x04, len=1, payload[0]=0x11, response 0xEE.
REQ-031 SHALL cover: PLANK frame E2 plus 18 bytes of 0x32 with a correct chk -> len=18, all payload bytes 0x32, response 0xEE.
REQ-032 SHALL cover: ACU frame with chk corrupted by XOR 0x01 -> no o_frm_valid, err=1, response 0xFF.
REQ-033 SHALL cover: garbage 00 13 AA 04 11 BF 55 -> exactly one good frame.
REQ-034 SHALL cover: cmd 0x07 -> err=3 and no response; a following good SNSR frame -> err=0 and response 0xEE.
REQ-035 SHALL cover, with UART_FRAME_TIMEOUT_EN: stop after 3 PLANK bytes and idle TIMEOUT_CYC clocks -> err=4, response 0xFF, FSM in IDLE. Also hold i_rsp_ready=0 across two frames -> only the second response is seen.
